multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle MIPS control FSM. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and the 3-bit ALU_operation code consumed by the shared ALU. It samples ALU Zero for branches and handshakes with unified instruction/data memory through mem_ready.

Parameters:
- ALU_OP_W, 3, width of ALU_operation (ADD 000, SUB 100, AND 001, OR 101, XOR 010, LUI 110)
- STATE_W, 4, state register width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; stable from the cycle after the IR write
- funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_en  out  1  PC load = PCWrite | (PCWriteCond & Zero)
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1  1 = MDR, 0 = ALUOut
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- ExtZero  out  1  zero-extend immediate (andi/ori/xori)
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALU_operation  out  3  operation code to the ALU
- illegal  out  1  one-cycle pulse on an unsupported instruction

Behaviour:
- Reset (async): state = FETCH. While rst_n = 0, all enables (pc_en, MemRead, MemWrite, IRWrite, RegWrite) and illegal are forced to 0, and all selects are 0. Reset mid-instruction abandons the instruction with no partial writes after the reset edge.
- Outputs are Moore, decoded combinationally from the state. Exception: ALU_operation in R_EXEC and I_EXEC also depends on funct/opcode. pc_en also uses Zero.
- FETCH:
  - Outputs: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALU ADD, PCSource = 00.
  - Stay in FETCH while mem_ready = 0; IRWrite and pc_en stay 0 while waiting.
  - When mem_ready = 1: IRWrite = 1 and PCWrite = 1 in that cycle, then go to DECODE.
- DECODE:
  - Outputs: ALUSrcA = 0, ALUSrcB = 11, ALU ADD (branch target).
  - Next state by opcode: 000000 -> R_EXEC (funct 20/22/24/25/26 hex only); 23/2B -> MEM_ADDR; 04 -> BRANCH; 02 -> JUMP; 08/0C/0D/0E/0F -> I_EXEC.
  - Any other opcode/funct: illegal = 1 for this cycle, then FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ADD. Next state: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: MemRead = 1, IorD = 1. Hold until mem_ready, then MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Then FETCH.
- MEM_WR: MemWrite = 1, IorD = 1. Hold until mem_ready, then FETCH. MemWrite remains asserted while waiting.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00. funct 20 -> ADD, 22 -> SUB, 24 -> AND, 25 -> OR, 26 -> XOR. Then R_WB.
- R_WB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Then FETCH.
- I_EXEC:
  - ALUSrcA = 1, ALUSrcB = 10.
  - ALU op by opcode: addi -> ADD, andi -> AND, ori -> OR, xori -> XOR, lui -> LUI.
  - ExtZero = 1 for andi/ori/xori.
  - Then I_WB.
- I_WB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Then FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, SUB, PCWriteCond = 1, PCSource = 01. pc_en = Zero. Then FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Then FETCH.
- Latency with mem_ready = 1 throughout: R/I-type 4 cycles, lw 5, sw 4, beq 3, j 3. Each cycle mem_ready is held low adds one cycle.
- Unused state encodings go to FETCH.

Optional Feature:
- MULTICYCLE_CTRL_BNE_EN defined: opcode 05 (bne) decodes to BRANCH, and pc_en = ~Zero for bne.
- Undefined: opcode 05 is illegal.

Decomposition:
- Package mips_ctrl_pkg holds: state enum, opcode and funct constants, ALU op codes, and ALUSrcB/PCSource encodings.
- One sub-module, alu_op_decoder (combinational): inputs state class, opcode, funct; output ALU_operation.

Test Plan:
- Reset then add: rst_n low for 3 cycles, then opcode 00, funct 20, mem_ready = 1. Expect FETCH/DECODE/R_EXEC/R_WB; ALU_operation = 000 in R_EXEC; RegWrite = 1 and RegDst = 1 in cycle 4 only.
- lw with memory stall: opcode 23, mem_ready low for 2 cycles in MEM_RD. Expect MemRead = 1 and IorD = 1 for 3 cycles; RegWrite = 1 and MemtoReg = 1 exactly once; 7 cycles total.
- beq: opcode 04 with Zero = 1 gives pc_en = 1 in BRANCH and ALU_operation = 100. Repeat with Zero = 0: pc_en = 0.
- lui and ori: opcode 0F gives ALU_operation = 110 with ExtZero = 0. Opcode 0D gives 101 with ExtZero = 1.
- Illegal instruction: opcode 3F, or opcode 00 with funct 2A. Expect illegal pulse in DECODE, return to FETCH, and no RegWrite/MemWrite. With MULTICYCLE_CTRL_BNE_EN, opcode 05 and Zero = 0 gives pc_en = 1.
- Reset mid-MEM_WR: assert rst_n = 0 while sw waits on mem_ready. Expect MemWrite to drop to 0 immediately (asynchronous), and state = FETCH after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg : shared types and encodings for the multi-cycle MIPS control
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (bne decodes to BRANCH)
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  localparam int c_alu_op_w = 3;
  localparam int c_state_w  = 4;

  typedef enum logic [c_state_w-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    I_EXEC   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  // Which rule the ALU op decoder applies in the current state
  typedef enum logic [1:0] {
    ALU_CLS_ADD = 2'd0,
    ALU_CLS_SUB = 2'd1,
    ALU_CLS_R   = 2'd2,
    ALU_CLS_I   = 2'd3
  } alu_cls_t;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_beq   = 6'h04;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam logic [5:0] c_op_bne   = 6'h05;
`endif
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_andi  = 6'h0C;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_xori  = 6'h0E;
  localparam logic [5:0] c_op_lui   = 6'h0F;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_xor = 6'h26;

  localparam logic [c_alu_op_w-1:0] c_alu_add = 3'b000;
  localparam logic [c_alu_op_w-1:0] c_alu_sub = 3'b100;
  localparam logic [c_alu_op_w-1:0] c_alu_and = 3'b001;
  localparam logic [c_alu_op_w-1:0] c_alu_or  = 3'b101;
  localparam logic [c_alu_op_w-1:0] c_alu_xor = 3'b010;
  localparam logic [c_alu_op_w-1:0] c_alu_lui = 3'b110;

  localparam logic [1:0] c_srcb_rt     = 2'b00;
  localparam logic [1:0] c_srcb_four   = 2'b01;
  localparam logic [1:0] c_srcb_imm    = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  function automatic logic is_rtype_funct(input logic [5:0] fn);
    return (fn == c_fn_add) || (fn == c_fn_sub) || (fn == c_fn_and) ||
           (fn == c_fn_or)  || (fn == c_fn_xor);
  endfunction

  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == c_op_andi) || (op == c_op_ori) || (op == c_op_xori);
  endfunction

  // FETCH doubles as the "unsupported instruction" result
  function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
    state_t t;
    t = FETCH;
    case (op)
      c_op_rtype: if (is_rtype_funct(fn)) t = R_EXEC;
      c_op_lw, c_op_sw: t = MEM_ADDR;
      c_op_beq: t = BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
      c_op_bne: t = BRANCH;
`endif
      c_op_j: t = JUMP;
      c_op_addi, c_op_andi, c_op_ori, c_op_xori, c_op_lui: t = I_EXEC;
      default: t = FETCH;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decoder.sv
// ============================================================================
// alu_op_decoder : maps state class, opcode and funct to the ALU operation code
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic [1:0]          alu_cls,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_operation
);

  always_comb begin
    alu_operation = c_alu_add;
    case (alu_cls_t'(alu_cls))
      ALU_CLS_SUB: alu_operation = c_alu_sub;
      ALU_CLS_R: begin
        case (funct)
          c_fn_sub: alu_operation = c_alu_sub;
          c_fn_and: alu_operation = c_alu_and;
          c_fn_or:  alu_operation = c_alu_or;
          c_fn_xor: alu_operation = c_alu_xor;
          default:  alu_operation = c_alu_add;
        endcase
      end
      ALU_CLS_I: begin
        case (opcode)
          c_op_andi: alu_operation = c_alu_and;
          c_op_ori:  alu_operation = c_alu_or;
          c_op_xori: alu_operation = c_alu_xor;
          c_op_lui:  alu_operation = c_alu_lui;
          default:   alu_operation = c_alu_add;
        endcase
      end
      default: alu_operation = c_alu_add;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : multi-cycle MIPS control FSM driving datapath enables/ALU op
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (bne support, pc_en = ~Zero)
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                ExtZero,
  output logic [1:0]          PCSource,
  output logic [ALU_OP_W-1:0] ALU_operation,
  output logic                illegal
);

  logic [STATE_W-1:0] r_state;
  state_t             w_state;
  state_t             w_next_state;
  logic               w_pc_write;
  logic               w_pc_write_cond;
  logic               w_branch_taken;
  logic [1:0]         w_alu_cls;

  assign w_state = state_t'(r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state    = FETCH;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_branch_taken  = Zero;
    w_alu_cls       = ALU_CLS_ADD;
    IorD            = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    IRWrite         = 1'b0;
    RegDst          = 1'b0;
    MemtoReg        = 1'b0;
    RegWrite        = 1'b0;
    ALUSrcA         = 1'b0;
    ALUSrcB         = c_srcb_rt;
    ExtZero         = 1'b0;
    PCSource        = c_pcsrc_alu;
    illegal         = 1'b0;

    case (w_state)
      FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = c_srcb_four;
        PCSource = c_pcsrc_alu;
        if (mem_ready) begin
          IRWrite      = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = DECODE;
        end else begin
          w_next_state = FETCH;
        end
      end
      DECODE: begin
        ALUSrcB      = c_srcb_imm_sh;
        w_next_state = decode_target(opcode, funct);
        illegal      = (w_next_state == FETCH);
      end
      MEM_ADDR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = c_srcb_imm;
        w_next_state = (opcode == c_op_sw) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        MemRead      = 1'b1;
        IorD         = 1'b1;
        w_next_state = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WR: begin
        MemWrite     = 1'b1;
        IorD         = 1'b1;
        w_next_state = mem_ready ? FETCH : MEM_WR;
      end
      R_EXEC: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = c_srcb_rt;
        w_alu_cls    = ALU_CLS_R;
        w_next_state = R_WB;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      I_EXEC: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = c_srcb_imm;
        w_alu_cls    = ALU_CLS_I;
        ExtZero      = is_zext_op(opcode);
        w_next_state = I_WB;
      end
      I_WB: begin
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA         = 1'b1;
        ALUSrcB         = c_srcb_rt;
        w_alu_cls       = ALU_CLS_SUB;
        w_pc_write_cond = 1'b1;
        PCSource        = c_pcsrc_aluout;
`ifdef MULTICYCLE_CTRL_BNE_EN
        if (opcode == c_op_bne) w_branch_taken = ~Zero;
`endif
      end
      JUMP: begin
        w_pc_write = 1'b1;
        PCSource   = c_pcsrc_jump;
      end
      default: w_next_state = FETCH;
    endcase

    pc_en = w_pc_write | (w_pc_write_cond & w_branch_taken);

    // Reset overrides everything, so an abandoned instruction cannot write
    if (!rst_n) begin
      pc_en     = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = c_srcb_rt;
      ExtZero   = 1'b0;
      PCSource  = c_pcsrc_alu;
      illegal   = 1'b0;
      w_alu_cls = ALU_CLS_ADD;
    end
  end

  alu_op_decoder #(
    .ALU_OP_W (ALU_OP_W)
  ) u_alu_op_decoder (
    .alu_cls       (w_alu_cls),
    .opcode        (opcode),
    .funct         (funct),
    .alu_operation (ALU_operation)
  );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : instruction-level reference model vs multicycle_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h0;
  logic [5:0] funct = 6'h0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, ExtZero, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALU_operation;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALU_OP_W(3), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtZero(ExtZero),
    .PCSource(PCSource), .ALU_operation(ALU_operation), .illegal(illegal)
  );

  typedef struct packed {
    logic       pc_en, iord, mrd, mwr, irw, regdst, m2r, rw, srca;
    logic [1:0] srcb;
    logic       extz;
    logic [1:0] pcsrc;
    logic [2:0] alu;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic       mr;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
    outs_t      exp;
  } cyc_t;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_J = 6;

  cyc_t  exp_q[$];
  outs_t obs_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic outs_t sample();
    outs_t o;
    o.pc_en = pc_en;   o.iord = IorD;      o.mrd = MemRead;  o.mwr = MemWrite;
    o.irw = IRWrite;   o.regdst = RegDst;  o.m2r = MemtoReg; o.rw = RegWrite;
    o.srca = ALUSrcA;  o.srcb = ALUSrcB;   o.extz = ExtZero; o.pcsrc = PCSource;
    o.alu = ALU_operation; o.ill = illegal;
    return o;
  endfunction

  // ---------------- reference model (instruction level) ----------------
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                     fn == 6'h25 || fn == 6'h26) ? K_R : K_ILL;
      6'h02: return K_J;
      6'h04: return K_BR;
`ifdef MULTICYCLE_CTRL_BNE_EN
      6'h05: return K_BR;
`endif
      6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return K_I;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input int k, input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] r;
    r = 3'b000;
    if (k == K_R) begin
      case (fn)
        6'h22: r = 3'b100;
        6'h24: r = 3'b001;
        6'h25: r = 3'b101;
        6'h26: r = 3'b010;
        default: r = 3'b000;
      endcase
    end else if (k == K_I) begin
      case (op)
        6'h0C: r = 3'b001;
        6'h0D: r = 3'b101;
        6'h0E: r = 3'b010;
        6'h0F: r = 3'b110;
        default: r = 3'b000;
      endcase
    end else if (k == K_BR) begin
      r = 3'b100;
    end
    return r;
  endfunction

  task automatic push(input logic mr, input logic z, input logic [5:0] op,
                      input logic [5:0] fn, input outs_t e);
    cyc_t c;
    c.mr = mr; c.z = z; c.op = op; c.fn = fn; c.exp = e;
    exp_q.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Per-cycle expected outputs of one whole instruction, with memory stalls
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fstall, input int mstall);
    outs_t e;
    int    k;
    k = classify(op, fn);
    for (int i = 0; i < fstall; i++) begin
      e = '0; e.mrd = 1'b1; e.srcb = 2'b01;
      push(1'b0, rb(), 6'($urandom), 6'($urandom), e);
    end
    e = '0; e.mrd = 1'b1; e.srcb = 2'b01; e.irw = 1'b1; e.pc_en = 1'b1;
    push(1'b1, rb(), 6'($urandom), 6'($urandom), e);
    e = '0; e.srcb = 2'b11; e.ill = (k == K_ILL);
    push(rb(), rb(), op, fn, e);
    case (k)
      K_R: begin
        e = '0; e.srca = 1'b1; e.alu = alu_of(k, op, fn); push(rb(), rb(), op, fn, e);
        e = '0; e.rw = 1'b1; e.regdst = 1'b1;              push(rb(), rb(), op, fn, e);
      end
      K_I: begin
        e = '0; e.srca = 1'b1; e.srcb = 2'b10; e.alu = alu_of(k, op, fn);
        e.extz = (op == 6'h0C || op == 6'h0D || op == 6'h0E);
        push(rb(), rb(), op, fn, e);
        e = '0; e.rw = 1'b1; push(rb(), rb(), op, fn, e);
      end
      K_LW, K_SW: begin
        e = '0; e.srca = 1'b1; e.srcb = 2'b10; push(rb(), rb(), op, fn, e);
        e = '0; e.iord = 1'b1;
        if (k == K_LW) e.mrd = 1'b1; else e.mwr = 1'b1;
        for (int i = 0; i < mstall; i++) push(1'b0, rb(), op, fn, e);
        push(1'b1, rb(), op, fn, e);
        if (k == K_LW) begin
          e = '0; e.rw = 1'b1; e.m2r = 1'b1; push(rb(), rb(), op, fn, e);
        end
      end
      K_BR: begin
        e = '0; e.srca = 1'b1; e.alu = 3'b100; e.pcsrc = 2'b01;
        e.pc_en = (op == 6'h05) ? ~z : z;
        push(rb(), z, op, fn, e);
      end
      K_J: begin
        e = '0; e.pc_en = 1'b1; e.pcsrc = 2'b10; push(rb(), rb(), op, fn, e);
      end
      default: ;
    endcase
  endtask

  // Plays the first n queued cycles; called right after a rising edge
  task automatic run_cycles(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      mem_ready = exp_q[i].mr; Zero = exp_q[i].z;
      opcode = exp_q[i].op;    funct = exp_q[i].fn;
      #2;
      obs_q.push_back(sample());
      @(posedge clk); #1;
    end
  endtask

  // ------------------------------ tests ------------------------------
  task automatic test_reset();
    outs_t o;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rb(); Zero = rb(); opcode = 6'($urandom); funct = 6'($urandom);
      #2;
      o = sample();
      n_tests++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL reset_outs cyc %0d: got %h expected %h", i, o, outs_t'('0));
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    exp_q.delete();
    model_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_cycles(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i].exp) begin
        n_fail++;
        $display("FAIL add cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i].exp);
      end
    end
  endtask

  task automatic test_lw_stall();
    exp_q.delete();
    model_instr(6'h23, 6'($urandom), 1'b0, 0, 2);
    model_instr(6'h2B, 6'($urandom), 1'b1, 1, 1);
    run_cycles(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i].exp) begin
        n_fail++;
        $display("FAIL lw_sw_stall cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i].exp);
      end
    end
  endtask

  task automatic test_beq();
    exp_q.delete();
    model_instr(6'h04, 6'($urandom), 1'b1, 0, 0);
    model_instr(6'h04, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'h02, 6'($urandom), 1'b0, 0, 0);
    run_cycles(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i].exp) begin
        n_fail++;
        $display("FAIL beq_j cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i].exp);
      end
    end
  endtask

  task automatic test_lui_ori();
    exp_q.delete();
    model_instr(6'h0F, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'h0D, 6'($urandom), 1'b0, 0, 0);
    run_cycles(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i].exp) begin
        n_fail++;
        $display("FAIL lui_ori cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i].exp);
      end
    end
  endtask

  task automatic test_illegal();
    exp_q.delete();
    model_instr(6'h3F, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'h00, 6'h2A, 1'b0, 0, 0);
    model_instr(6'h05, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'h00, 6'h22, 1'b0, 0, 0);
    run_cycles(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i].exp) begin
        n_fail++;
        $display("FAIL illegal cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid_sw();
    outs_t o;
    exp_q.delete();
    model_instr(6'h2B, 6'($urandom), 1'b0, 0, 6);
    run_cycles(5);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i].exp) begin
        n_fail++;
        $display("FAIL sw_pre_reset cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i].exp);
      end
    end
    mem_ready = 1'b0;
    #1;
    o = sample();
    n_tests++;
    if (o.mwr !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_waiting MemWrite: got %b expected 1", o.mwr);
    end
    rst_n = 1'b0;
    #1;
    o = sample();
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outs: got %h expected %h", o, outs_t'('0));
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    o = sample();
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL held_reset_outs: got %h expected %h", o, outs_t'('0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    model_instr(6'h00, 6'h24, 1'b0, 1, 0);
    run_cycles(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i].exp) begin
        n_fail++;
        $display("FAIL post_reset_and cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[13] = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C,
                            6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    logic [5:0] fns[7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00};
    logic [5:0] op, fn;
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      model_instr(op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_cycles(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i].exp) begin
        n_fail++;
        $display("FAIL random cyc %0d op %h fn %h: got %h expected %h",
                 i, exp_q[i].op, exp_q[i].fn, obs_q[i], exp_q[i].exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_beq();
    test_lui_ori();
    test_illegal();
    test_reset_mid_sw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
